// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin owner of a single shared 32-bit binary-to-BCD
// converter. Latches the winner's operand, drives the converter trigger/idle
// handshake (re-triggering if the converter never starts), and returns the
// captured BCD result to the winner with a one-cycle done pulse.
module bcd_conv_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  in_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          bcd_out,
  output logic                 busy,
  output logic                 conv_trigger,
  output logic [31:0]          conv_in,
  input  logic                 conv_idle,
  input  logic [31:0]          conv_bcd
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(START_TIMEOUT);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [2:0] {
    S_ARB    = 3'd0,
    S_LAUNCH = 3'd1,
    S_START  = 3'd2,
    S_BUSY   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [31:0]        bcd_q, bcd_d;
  logic [31:0]        conv_in_q, conv_in_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W:0]     cand_sum;
  logic [31:0]        win_data;

  // Round-robin search: first requester at or after ptr, wrapping mod N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand_sum >= N_EXT) cand_sum = cand_sum - N_EXT;
      cand_idx = cand_sum[IDX_W-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Select the candidate winner's operand for latching on the grant edge.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = in_data[32*i +: 32];
    end
  end

  // Next-state and register updates for the arbitration/handshake FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = done_q;
    bcd_d     = bcd_q;
    conv_in_d = conv_in_q;
    case (state_q)
      S_ARB: begin
        // conv_idle gate also covers a converter still running after reset
        if (conv_idle && win_found) begin
          win_d     = win_idx;
          conv_in_d = win_data;
          grant_d   = ONE_HOT0 << win_idx;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (!conv_idle) begin
          state_d = S_BUSY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TMO_LIM) state_d = S_LAUNCH;
        end
      end
      S_BUSY: begin
        if (conv_idle) begin
          bcd_d   = conv_bcd;
          done_d  = ONE_HOT0 << win_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = '0;
        grant_d = '0;
        ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
        state_d = S_ARB;
      end
      default: begin
        done_d  = '0;
        grant_d = '0;
        state_d = S_ARB;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ARB;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      bcd_q     <= '0;
      conv_in_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      conv_in_q <= conv_in_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign bcd_out      = bcd_q;
  assign conv_in      = conv_in_q;
  assign busy         = (state_q != S_ARB);
  assign conv_trigger = (state_q == S_LAUNCH);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioral 63-cycle converter.
module tb_bcd_conv_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] in_data;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [31:0]     bcd_out;
  logic            busy;
  logic            conv_trigger;
  logic [31:0]     conv_in;
  logic            conv_idle = 1'b1;
  logic [31:0]     conv_bcd  = '0;

  typedef struct packed {
    logic [N-1:0] dn;
    logic [31:0]  bcd;
    logic [31:0]  cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] trig_q[$];

  int cyc       = 0;
  int n_tests   = 0;
  int n_fail    = 0;
  int tmo_cnt   = 0;
  int ign_req   = 0;
  int ign_done  = 0;
  int cv_cnt    = 0;
  bit finish_req = 1'b0;

  bcd_conv_arbiter #(.N_REQ(N), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data),
    .grant(grant), .done(done), .bcd_out(bcd_out), .busy(busy),
    .conv_trigger(conv_trigger), .conv_in(conv_in),
    .conv_idle(conv_idle), .conv_bcd(conv_bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] t;
    logic [31:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Converter model: idle low for 63 cycles after an accepted trigger,
  // result taken from conv_in when it finishes; can ignore triggers on demand.
  always @(posedge clk) begin
    if (cv_cnt != 0) begin
      cv_cnt <= cv_cnt - 1;
      if (cv_cnt == 1) begin
        conv_idle <= 1'b1;
        conv_bcd  <= to_bcd(conv_in);
      end
    end else if (conv_trigger && conv_idle) begin
      if (ign_req != ign_done) begin
        ign_done <= ign_done + 1;
      end else begin
        conv_idle <= 1'b0;
        cv_cnt    <= 63;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares everything the DUT presents against queued expectations.
  initial begin : monitor
    exp_t        e;
    logic [31:0] tc;
    bit          after_done;
    after_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_bcd_out", 64'(bcd_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_trigger", 64'(conv_trigger), 64'(0));
        chk("rst_conv_in", 64'(conv_in), 64'(0));
        after_done = 1'b0;
      end else begin
        if (after_done) begin
          chk("post_done_busy", 64'(busy), 64'(0));
          chk("post_done_grant", 64'(grant), 64'(0));
          chk("post_done_done", 64'(done), 64'(0));
          after_done = 1'b0;
        end
        if (conv_trigger) begin
          chk("trig_while_conv_idle", 64'(conv_idle), 64'(1));
          chk("trig_expected", 64'(trig_q.size() > 0), 64'(1));
          if (trig_q.size() > 0) begin
            tc = trig_q.pop_front();
            chk("trig_cycle", 64'(cyc), 64'(tc));
          end
        end
        if (done != '0) begin
          chk("done_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_vec", 64'(done), 64'(e.dn));
            chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("grant_owner", 64'(grant), 64'(e.dn));
          end
          after_done = 1'b1;
        end
      end
      if (finish_req) begin
        chk("exp_drained", 64'(exp_q.size()), 64'(0));
        chk("trig_drained", 64'(trig_q.size()), 64'(0));
        chk("no_wait_timeout", 64'(tmo_cnt), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  task automatic issue(input int idx, input logic [31:0] op);
    in_data[32*idx +: 32] = op;
    req[idx] = 1'b1;
  endtask

  task automatic push_trig(input int cy);
    trig_q.push_back(32'(cy));
  endtask

  task automatic push_exp(input logic [N-1:0] dn, input logic [31:0] bcd, input int cy);
    exp_t e;
    e.dn  = dn;
    e.bcd = bcd;
    e.cyc = 32'(cy);
    exp_q.push_back(e);
  endtask

  // Requester behaviour: drop req on seeing its done bit; bounded wait.
  task automatic wait_done_drop(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge clk);
      if (done != '0) begin
        req  = req & ~done;
        seen = 1'b1;
      end
    end
    if (!seen) tmo_cnt++;
  endtask

  initial begin : stimulus
    int c;
    rst     = 1'b1;
    req     = '0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // All four at once, served 0,1,2,3 at 67-cycle spacing.
    c = cyc;
    issue(0, 32'd0);
    issue(1, 32'd9);
    issue(2, 32'd10);
    issue(3, 32'd99999999);
    push_trig(c + 1);   push_exp(4'b0001, 32'h00000000, c + 66);
    push_trig(c + 68);  push_exp(4'b0010, 32'h00000009, c + 133);
    push_trig(c + 135); push_exp(4'b0100, 32'h00000010, c + 200);
    push_trig(c + 202); push_exp(4'b1000, 32'h99999999, c + 267);
    repeat (4) wait_done_drop(200);
    @(negedge clk);

    // Fairness: req[0] re-asserted right after its done, single req[2].
    c = cyc;
    issue(0, 32'd5);
    issue(2, 32'd42);
    push_trig(c + 1);   push_exp(4'b0001, 32'h00000005, c + 66);
    push_trig(c + 68);  push_exp(4'b0100, 32'h00000042, c + 133);
    push_trig(c + 135); push_exp(4'b0001, 32'h00000005, c + 200);
    wait_done_drop(200);
    @(negedge clk);
    req[0] = 1'b1;
    wait_done_drop(200);
    wait_done_drop(200);
    @(negedge clk);

    // Single request, reference latency.
    c = cyc;
    issue(0, 32'd1234567);
    push_trig(c + 1); push_exp(4'b0001, 32'h01234567, c + 66);
    wait_done_drop(200);
    @(negedge clk);

    // Out-of-range operand, changed during BUSY.
    c = cyc;
    issue(1, 32'hFFFFFFFF);
    push_trig(c + 1); push_exp(4'b0010, 32'h94967295, c + 66);
    repeat (20) @(negedge clk);
    in_data[63:32] = 32'd0;
    wait_done_drop(100);
    @(negedge clk);

    // Reset mid-conversion; converter keeps running, ptr must restart at 0.
    c = cyc;
    issue(2, 32'd77);
    push_trig(c + 1);
    repeat (30) @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    issue(3, 32'd11);
    issue(1, 32'd87654321);
    push_trig(c + 66); push_exp(4'b0010, 32'h87654321, c + 131);
    wait_done_drop(200);
    req = '0;
    @(negedge clk);

    // Start timeout: first trigger ignored, re-trigger after 4 START cycles.
    c = cyc;
    ign_req++;
    issue(0, 32'd123456789);
    push_trig(c + 1);
    push_trig(c + 6);
    push_exp(4'b0001, 32'h23456789, c + 71);
    wait_done_drop(200);

    repeat (3) @(negedge clk);
    finish_req = 1'b1;
  end

endmodule
